// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU memory subsystem.
//   state_e       : run-control FSM states (IDLE -> RUN -> DONE -> IDLE)
//   HOST_SEL_*    : host_sel encodings for the host load port
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic HOST_SEL_IMEM = 1'b0;
  localparam logic HOST_SEL_DMEM = 1'b1;

endpackage

// File: rtl/mp_ram.sv
// Multi-port RAM with 1-cycle read-first reads and priority writes.
//   clk_i, rst_ni       : clock, async active-low reset (read regs only; array is not reset)
//   rd_en_i/rd_addr_i   : per-port read request (packed addresses)
//   rdata_o/rvalid_o    : read data (held between valid reads) and valid, 1 cycle later
//   wr_en_i/wr_addr_i/wdata_i : per-port write; highest-index port wins on equal addresses
//   collision_o         : two or more enabled writes to one address this cycle
//   addr_err_o          : an enabled access addresses >= DEPTH this cycle
module mp_ram #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned NPORTS     = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NPORTS-1:0]            rd_en_i,
  input  logic [NPORTS*ADDR_WIDTH-1:0] rd_addr_i,
  output logic [NPORTS*WIDTH-1:0]      rdata_o,
  output logic [NPORTS-1:0]            rvalid_o,
  input  logic [NPORTS-1:0]            wr_en_i,
  input  logic [NPORTS*ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [NPORTS*WIDTH-1:0]      wdata_i,
  output logic                         collision_o,
  output logic                         addr_err_o
);

  logic [WIDTH-1:0]        mem_q [DEPTH];
  logic [NPORTS*WIDTH-1:0] rdata_q;
  logic [NPORTS-1:0]       rvalid_q;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  // Later loop iterations override earlier ones, so the highest port wins.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NPORTS; i++) begin
      if (wr_en_i[i] && in_range(wr_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        mem_q[wr_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH]] <= wdata_i[i*WIDTH +: WIDTH];
      end
    end
  end

  // Reads sample the array before this edge's writes land (read-first).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      rvalid_q <= rd_en_i;
      for (int i = 0; i < NPORTS; i++) begin
        if (rd_en_i[i]) begin
          rdata_q[i*WIDTH +: WIDTH] <= in_range(rd_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH]) ?
                                       mem_q[rd_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH]] : '0;
        end
      end
    end
  end

  always_comb begin
    collision_o = 1'b0;
    addr_err_o  = 1'b0;
    for (int i = 0; i < NPORTS; i++) begin
      if (rd_en_i[i] && !in_range(rd_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH])) addr_err_o = 1'b1;
      if (wr_en_i[i] && !in_range(wr_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH])) addr_err_o = 1'b1;
      for (int j = i + 1; j < NPORTS; j++) begin
        if (wr_en_i[i] && wr_en_i[j] &&
            wr_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH] == wr_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH]) begin
          collision_o = 1'b1;
        end
      end
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;

endmodule

// File: rtl/cpu_mem_subsystem.sv
// CPU memory subsystem: instruction memory, NUM_PORTS-port data memory, host load port and a
// run-control FSM (IDLE -> RUN -> DONE) with watchdog and saturating run-cycle counter.
//   clk, rstn            : clock, async active-low reset
//   start, cpu_start, cpu_done, done : run handshake (start edge in, pulses out)
//   host_*               : host load port, accepted only while host_ready (IDLE)
//   imem_* / dmem_*      : CPU-facing memory ports, honoured only in RUN
//   timeout, collision_err, addr_err, run_cycles : sticky status and cycle count
module cpu_mem_subsystem
  import cpu_mem_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH    = 10,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned MEM_DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH     = 3,
  parameter int unsigned NUM_PORTS      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            start,
  input  logic                            host_wr_en,
  input  logic                            host_sel,
  input  logic [ADDR_WIDTH-1:0]           host_addr,
  input  logic [INSTR_WIDTH-1:0]          host_wdata,
  output logic                            host_ready,
  output logic                            cpu_start,
  input  logic                            cpu_done,
  input  logic                            imem_rd_en,
  input  logic [ADDR_WIDTH-1:0]           imem_addr,
  output logic [INSTR_WIDTH-1:0]          imem_rdata,
  output logic                            imem_rvalid,
  input  logic [NUM_PORTS-1:0]            dmem_rd_en,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] dmem_rd_addr,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] dmem_rdata,
  output logic [NUM_PORTS-1:0]            dmem_rvalid,
  input  logic [NUM_PORTS-1:0]            dmem_wr_en,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] dmem_wr_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] dmem_wdata,
  output logic                            done,
  output logic                            timeout,
  output logic                            collision_err,
  output logic                            addr_err,
  output logic [CNT_WIDTH-1:0]            run_cycles
);

  state_e               state_q, state_d;
  logic                 start_q;
  logic                 cpu_start_q, cpu_start_d;
  logic                 timeout_q, timeout_d;
  logic                 coll_q, coll_d;
  logic                 addr_err_q, addr_err_d;
  logic [CNT_WIDTH-1:0] run_cycles_q, run_cycles_d;

  logic run, host_acc, limit_hit;
  logic im_wr_en, im_coll, im_aerr, dm_coll, dm_aerr;
  logic [NUM_PORTS-1:0]            dm_wr_en;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] dm_wr_addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0] dm_wdata;

  assign run        = (state_q == RUN);
  assign host_ready = (state_q == IDLE);
  assign host_acc   = host_wr_en & host_ready;
  assign im_wr_en   = host_acc & (host_sel == HOST_SEL_IMEM);
  assign limit_hit  = 32'(run_cycles_q) >= TIMEOUT_CYCLES - 1;

  // Outside RUN the host owns data-memory port 0; CPU writes are ignored.
  always_comb begin
    dm_wr_en   = run ? dmem_wr_en : '0;
    dm_wr_addr = dmem_wr_addr;
    dm_wdata   = dmem_wdata;
    if (!run) begin
      dm_wr_en[0]                  = host_acc & (host_sel == HOST_SEL_DMEM);
      dm_wr_addr[ADDR_WIDTH-1:0]   = host_addr;
      dm_wdata[DATA_WIDTH-1:0]     = host_wdata[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    cpu_start_d  = 1'b0;
    timeout_d    = timeout_q;
    coll_d       = coll_q | dm_coll | im_coll;
    addr_err_d   = addr_err_q | dm_aerr | im_aerr;
    run_cycles_d = run_cycles_q;
    unique case (state_q)
      IDLE: begin
        if (start && !start_q) begin
          state_d      = RUN;
          cpu_start_d  = 1'b1;
          run_cycles_d = '0;
          timeout_d    = 1'b0;
          coll_d       = 1'b0;
        end
      end
      RUN: begin
        run_cycles_d = (&run_cycles_q) ? run_cycles_q : run_cycles_q + 1'b1;
        // cpu_done has priority over the watchdog when both fire together.
        if (cpu_done) begin
          state_d = DONE;
        end else if (limit_hit) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      cpu_start_q  <= 1'b0;
      timeout_q    <= 1'b0;
      coll_q       <= 1'b0;
      addr_err_q   <= 1'b0;
      run_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      start_q      <= start;
      cpu_start_q  <= cpu_start_d;
      timeout_q    <= timeout_d;
      coll_q       <= coll_d;
      addr_err_q   <= addr_err_d;
      run_cycles_q <= run_cycles_d;
    end
  end

  mp_ram #(
    .WIDTH     (INSTR_WIDTH),
    .DEPTH     (MEM_DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .NPORTS    (1)
  ) u_imem (
    .clk_i      (clk),
    .rst_ni     (rstn),
    .rd_en_i    (imem_rd_en & run),
    .rd_addr_i  (imem_addr),
    .rdata_o    (imem_rdata),
    .rvalid_o   (imem_rvalid),
    .wr_en_i    (im_wr_en),
    .wr_addr_i  (host_addr),
    .wdata_i    (host_wdata),
    .collision_o(im_coll),
    .addr_err_o (im_aerr)
  );

  mp_ram #(
    .WIDTH     (DATA_WIDTH),
    .DEPTH     (MEM_DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .NPORTS    (NUM_PORTS)
  ) u_dmem (
    .clk_i      (clk),
    .rst_ni     (rstn),
    .rd_en_i    (dmem_rd_en & {NUM_PORTS{run}}),
    .rd_addr_i  (dmem_rd_addr),
    .rdata_o    (dmem_rdata),
    .rvalid_o   (dmem_rvalid),
    .wr_en_i    (dm_wr_en),
    .wr_addr_i  (dm_wr_addr),
    .wdata_i    (dm_wdata),
    .collision_o(dm_coll),
    .addr_err_o (dm_aerr)
  );

  assign cpu_start     = cpu_start_q;
  assign done          = (state_q == DONE);
  assign timeout       = timeout_q;
  assign collision_err = coll_q;
  assign addr_err      = addr_err_q;
  assign run_cycles    = run_cycles_q;

endmodule

// File: tb/tb_cpu_mem_subsystem.sv
module tb_cpu_mem_subsystem;

  localparam int DEPTH = 6;  // main DUT: addresses 6 and 7 are out of range

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        start = 1'b0;
  logic        host_wr_en = 1'b0;
  logic        host_sel = 1'b0;
  logic [2:0]  host_addr = '0;
  logic [9:0]  host_wdata = '0;
  logic        cpu_done = 1'b0;
  logic        imem_rd_en = 1'b0;
  logic [2:0]  imem_addr = '0;
  logic [1:0]  dmem_rd_en = '0;
  logic [5:0]  dmem_rd_addr = '0;
  logic [1:0]  dmem_wr_en = '0;
  logic [5:0]  dmem_wr_addr = '0;
  logic [15:0] dmem_wdata = '0;

  logic        host_ready, cpu_start, imem_rvalid, done, timeout, collision_err, addr_err;
  logic [9:0]  imem_rdata;
  logic [15:0] dmem_rdata;
  logic [1:0]  dmem_rvalid;
  logic [15:0] run_cycles;

  logic        wd_host_ready, wd_cpu_start, wd_imem_rvalid, wd_done, wd_timeout;
  logic        wd_collision_err, wd_addr_err;
  logic [9:0]  wd_imem_rdata;
  logic [15:0] wd_dmem_rdata;
  logic [1:0]  wd_dmem_rvalid;
  logic [15:0] wd_run_cycles;

  always #5 clk = ~clk;

  cpu_mem_subsystem #(.MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .start(start), .host_wr_en(host_wr_en), .host_sel(host_sel),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_ready(host_ready),
    .cpu_start(cpu_start), .cpu_done(cpu_done), .imem_rd_en(imem_rd_en),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
    .dmem_rd_en(dmem_rd_en), .dmem_rd_addr(dmem_rd_addr), .dmem_rdata(dmem_rdata),
    .dmem_rvalid(dmem_rvalid), .dmem_wr_en(dmem_wr_en), .dmem_wr_addr(dmem_wr_addr),
    .dmem_wdata(dmem_wdata), .done(done), .timeout(timeout), .collision_err(collision_err),
    .addr_err(addr_err), .run_cycles(run_cycles)
  );

  cpu_mem_subsystem #(.TIMEOUT_CYCLES(16)) dut_wd (
    .clk(clk), .rstn(rstn), .start(start), .host_wr_en(host_wr_en), .host_sel(host_sel),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_ready(wd_host_ready),
    .cpu_start(wd_cpu_start), .cpu_done(cpu_done), .imem_rd_en(imem_rd_en),
    .imem_addr(imem_addr), .imem_rdata(wd_imem_rdata), .imem_rvalid(wd_imem_rvalid),
    .dmem_rd_en(dmem_rd_en), .dmem_rd_addr(dmem_rd_addr), .dmem_rdata(wd_dmem_rdata),
    .dmem_rvalid(wd_dmem_rvalid), .dmem_wr_en(dmem_wr_en), .dmem_wr_addr(dmem_wr_addr),
    .dmem_wdata(dmem_wdata), .done(wd_done), .timeout(wd_timeout),
    .collision_err(wd_collision_err), .addr_err(wd_addr_err), .run_cycles(wd_run_cycles)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic sel, input logic [2:0] a, input logic [9:0] d);
    host_wr_en = 1'b1;
    host_sel   = sel;
    host_addr  = a;
    host_wdata = d;
    tick();
    host_wr_en = 1'b0;
  endtask

  // Leaves the bench in the first RUN cycle.
  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic end_run();
    imem_rd_en = 1'b0;
    dmem_rd_en = '0;
    dmem_wr_en = '0;
    cpu_done   = 1'b1;
    tick();
    cpu_done = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    tick();
  endtask

  typedef struct packed {
    logic       sel;
    logic [2:0] addr;
    logic [9:0] wdata;
    logic [9:0] want;
  } vec_t;

  vec_t       vecs[13];
  logic [9:0] imem_m[8];
  logic [7:0] dmem_m[8];

  initial begin : main
    int         n;
    int         p;
    int         rc;
    logic       seen;
    logic       e_iv, m_coll, m_aerr;
    logic [9:0] e_id;
    logic [1:0] e_dv;
    logic [7:0] e_dd[2];
    logic [2:0] a;

    vecs[0]  = '{1'b0, 3'd3, 10'h2A5, 10'h2A5};
    vecs[1]  = '{1'b1, 3'd5, 10'h03C, 10'h03C};
    vecs[2]  = '{1'b0, 3'd0, 10'h155, 10'h155};
    vecs[3]  = '{1'b1, 3'd0, 10'h044, 10'h044};
    vecs[4]  = '{1'b0, 3'd1, 10'h0AA, 10'h1C3};  // overwritten by row 6
    vecs[5]  = '{1'b1, 3'd1, 10'h1F3, 10'h0F3};  // only low 8 bits land
    vecs[6]  = '{1'b0, 3'd1, 10'h1C3, 10'h1C3};
    vecs[7]  = '{1'b1, 3'd2, 10'h05A, 10'h05A};
    vecs[8]  = '{1'b0, 3'd2, 10'h07E, 10'h07E};
    vecs[9]  = '{1'b1, 3'd3, 10'h0C8, 10'h0C8};
    vecs[10] = '{1'b0, 3'd4, 10'h300, 10'h300};
    vecs[11] = '{1'b1, 3'd4, 10'h201, 10'h001};
    vecs[12] = '{1'b0, 3'd5, 10'h3FF, 10'h3FF};

    // Reset values
    #2 rstn = 1'b0;
    repeat (2) tick();
    check("rst_host_ready", 32'(host_ready), 32'd1);
    check("rst_outs", 32'({cpu_start, done, timeout, collision_err, addr_err, imem_rvalid,
                           dmem_rvalid}), 32'd0);
    check("rst_data", 32'({imem_rdata, dmem_rdata, run_cycles}), 32'd0);
    rstn = 1'b1;
    tick();

    // Table: host load, then read every row back in one run
    for (int i = 0; i < 13; i++) begin
      host_write(vecs[i].sel, vecs[i].addr, vecs[i].wdata);
      if (vecs[i].sel) dmem_m[vecs[i].addr] = vecs[i].wdata[7:0];
      else             imem_m[vecs[i].addr] = vecs[i].wdata;
    end
    start_run();
    check("load_cpu_start", 32'(cpu_start), 32'd1);
    check("load_host_ready", 32'(host_ready), 32'd0);
    for (int i = 0; i < 13; i++) begin
      p = ((i >> 1) & 1) ^ 1;
      if (vecs[i].sel) begin
        dmem_rd_en[p] = 1'b1;
        dmem_rd_addr[p*3 +: 3] = vecs[i].addr;
      end else begin
        imem_rd_en = 1'b1;
        imem_addr  = vecs[i].addr;
      end
      tick();
      if (vecs[i].sel) begin
        check($sformatf("vec%0d_dvalid", i), 32'(dmem_rvalid[p]), 32'd1);
        check($sformatf("vec%0d_ddata", i), 32'(dmem_rdata[p*8 +: 8]), 32'(vecs[i].want));
      end else begin
        check($sformatf("vec%0d_ivalid", i), 32'(imem_rvalid), 32'd1);
        check($sformatf("vec%0d_idata", i), 32'(imem_rdata), 32'(vecs[i].want));
      end
      imem_rd_en = 1'b0;
      dmem_rd_en = '0;
    end
    end_run();

    // Run handshake: cpu_done 20 cycles after start
    start_run();
    check("hs_cpu_start", 32'(cpu_start), 32'd1);
    check("hs_cycles0", 32'(run_cycles), 32'd0);
    tick();
    check("hs_cpu_start_pulse", 32'(cpu_start), 32'd0);
    repeat (19) tick();
    check("hs_no_early_done", 32'(done), 32'd0);
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    check("hs_done", 32'(done), 32'd1);
    check("hs_run_cycles", 32'(run_cycles), 32'd21);
    check("hs_timeout", 32'(timeout), 32'd0);
    tick();
    check("hs_done_pulse", 32'(done), 32'd0);
    check("hs_idle", 32'(host_ready), 32'd1);

    // Write collision with read-first read of the same address
    start_run();
    check("coll_clear", 32'(collision_err), 32'd0);
    dmem_wr_en   = 2'b11;
    dmem_wr_addr = {3'd2, 3'd2};
    dmem_wdata   = {8'h22, 8'h11};
    dmem_rd_en   = 2'b01;
    dmem_rd_addr = {3'd0, 3'd2};
    tick();
    dmem_wr_en = '0;
    check("coll_old_data", 32'(dmem_rdata[7:0]), 32'(dmem_m[2]));
    check("coll_flag", 32'(collision_err), 32'd1);
    dmem_m[2] = 8'h22;
    tick();
    check("coll_winner", 32'(dmem_rdata[7:0]), 32'h22);
    end_run();
    check("coll_sticky", 32'(collision_err), 32'd1);

    // Gating: CPU ports ignored in IDLE, host ignored in RUN
    dmem_wr_en   = 2'b01;
    dmem_wr_addr = {3'd0, 3'd0};
    dmem_wdata   = {8'h77, 8'h77};
    dmem_rd_en   = 2'b11;
    dmem_rd_addr = {3'd0, 3'd0};
    tick();
    dmem_wr_en = '0;
    dmem_rd_en = '0;
    check("gate_idle_rvalid", 32'(dmem_rvalid), 32'd0);
    start_run();
    host_wr_en = 1'b1;
    host_sel   = 1'b1;
    host_addr  = 3'd0;
    host_wdata = 10'h0FF;
    check("gate_run_ready", 32'(host_ready), 32'd0);
    tick();
    host_wr_en   = 1'b0;
    dmem_rd_en   = 2'b10;
    dmem_rd_addr = {3'd0, 3'd0};
    tick();
    check("gate_mem_kept", 32'(dmem_rdata[15:8]), 32'(dmem_m[0]));
    check("gate_no_err", 32'(addr_err), 32'd0);
    end_run();

    // Out-of-range: host write dropped + flagged, read returns 0 with valid
    host_write(1'b1, 3'd6, 10'h0AB);
    check("oob_host_err", 32'(addr_err), 32'd1);
    start_run();
    dmem_rd_en   = 2'b01;
    dmem_rd_addr = {3'd0, 3'd6};
    tick();
    check("oob_read", 32'({dmem_rvalid[0], dmem_rdata[7:0]}), 32'h100);
    end_run();

    // Async reset in the 5th RUN cycle
    start_run();
    repeat (4) tick();
    check("mid_cycles", 32'(run_cycles), 32'd4);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_ready", 32'(host_ready), 32'd1);
    check("mid_rst_outs", 32'({cpu_start, done, addr_err, collision_err, run_cycles}), 32'd0);
    tick();
    rstn = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      tick();
      seen |= done | cpu_start;
    end
    check("mid_no_done", 32'(seen), 32'd0);
    start_run();
    imem_rd_en   = 1'b1;
    imem_addr    = 3'd3;
    dmem_rd_en   = 2'b10;
    dmem_rd_addr = {3'd5, 3'd0};
    tick();
    check("mid_imem_kept", 32'(imem_rdata), 32'h2A5);
    check("mid_dmem_kept", 32'(dmem_rdata[15:8]), 32'h3C);
    end_run();

    // Randomized run against the array model
    do_reset();
    e_id   = '0;
    e_iv   = 1'b0;
    e_dv   = '0;
    e_dd[0] = '0;
    e_dd[1] = '0;
    m_coll = 1'b0;
    m_aerr = 1'b0;
    start_run();
    rc = 1;
    for (int c = 0; c < 150; c++) begin
      imem_rd_en = 1'($urandom % 2);
      imem_addr  = 3'($urandom % 8);
      for (int q = 0; q < 2; q++) begin
        dmem_rd_en[q]          = 1'($urandom % 2);
        dmem_rd_addr[q*3 +: 3] = 3'($urandom % 8);
        dmem_wr_en[q]          = 1'($urandom % 2);
        dmem_wr_addr[q*3 +: 3] = 3'($urandom % 8);
        dmem_wdata[q*8 +: 8]   = 8'($urandom);
      end
      if ($urandom % 3 == 0) dmem_wr_addr[5:3] = dmem_wr_addr[2:0];
      // Reads see memory as it was before this cycle's writes.
      e_iv = imem_rd_en;
      if (imem_rd_en) begin
        if (imem_addr < DEPTH) e_id = imem_m[imem_addr];
        else begin e_id = '0; m_aerr = 1'b1; end
      end
      for (int q = 0; q < 2; q++) begin
        e_dv[q] = dmem_rd_en[q];
        a = dmem_rd_addr[q*3 +: 3];
        if (dmem_rd_en[q]) begin
          if (a < DEPTH) e_dd[q] = dmem_m[a];
          else begin e_dd[q] = '0; m_aerr = 1'b1; end
        end
      end
      if (dmem_wr_en == 2'b11 && dmem_wr_addr[2:0] == dmem_wr_addr[5:3]) m_coll = 1'b1;
      for (int q = 0; q < 2; q++) begin
        a = dmem_wr_addr[q*3 +: 3];
        if (dmem_wr_en[q]) begin
          if (a < DEPTH) dmem_m[a] = dmem_wdata[q*8 +: 8];
          else m_aerr = 1'b1;
        end
      end
      tick();
      rc++;
      check($sformatf("rnd%0d_imem", c), 32'({imem_rvalid, imem_rdata}), 32'({e_iv, e_id}));
      check($sformatf("rnd%0d_dmem", c), 32'({dmem_rvalid, dmem_rdata}),
            32'({e_dv, e_dd[1], e_dd[0]}));
      check($sformatf("rnd%0d_flags", c), 32'({collision_err, addr_err}), 32'({m_coll, m_aerr}));
    end
    imem_rd_en = 1'b0;
    dmem_rd_en = '0;
    dmem_wr_en = '0;
    cpu_done   = 1'b1;
    tick();
    cpu_done = 1'b0;
    check("rnd_done", 32'(done), 32'd1);
    check("rnd_run_cycles", 32'(run_cycles), 32'(rc));
    tick();

    // Watchdog on the TIMEOUT_CYCLES=16 instance
    do_reset();
    start_run();
    check("wd_cpu_start", 32'(wd_cpu_start), 32'd1);
    n = 1;
    while (!wd_done && n < 100) begin
      tick();
      n++;
    end
    check("wd_done_cycle", 32'(n), 32'd17);
    check("wd_timeout", 32'(wd_timeout), 32'd1);
    check("wd_run_cycles", 32'(wd_run_cycles), 32'd16);
    tick();
    check("wd_done_pulse", 32'(wd_done), 32'd0);
    check("wd_idle", 32'(wd_host_ready), 32'd1);

    // cpu_done on the very cycle the limit is reached: no timeout
    start_run();
    check("wd_timeout_cleared", 32'(wd_timeout), 32'd0);
    repeat (15) tick();
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    check("wd_tie_done", 32'(wd_done), 32'd1);
    check("wd_tie_timeout", 32'(wd_timeout), 32'd0);
    check("wd_tie_cycles", 32'(wd_run_cycles), 32'd16);
    tick();
    check("wd_quiet", 32'({wd_imem_rvalid, wd_dmem_rvalid, wd_collision_err, wd_addr_err,
                           wd_cpu_start}), 32'd0);
    check("wd_rdata", 32'({wd_imem_rdata, wd_dmem_rdata}), 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
